busio_data: RTL

- Memory-stage-side bus responder. Accepts the combinational data request the memory stage drives (address, size, signedness, load/store strobes, store data).
- Performs one transaction on the external word-wide valid/ready data bus, stalling the pipeline through `mem_busy` until done.
- Returns aligned, sign/zero-extended load data on `mem_load_data` in the cycle the stall releases.
- Sits between the memory stage/hazard unit and the external memory/MMIO interconnect.

---
 rtl/busio_pkg.sv | 44 ++++
 rtl/busio_load_align.sv | 31 +++
 rtl/busio_data.sv | 119 +++++++++++
 3 files changed

// File: rtl/busio_pkg.sv
// Shared encodings and helpers for the memory/fetch bus ports.
package busio_pkg;

  // Access size encodings carried on mem_size
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } state_e;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_lanes_t;

  // Replicate store data across lanes and build the byte enables.
  // Half accesses only honour offset[1]; misaligned offsets are never flagged.
  function automatic store_lanes_t store_lanes(logic [1:0] size, logic [1:0] offset,
                                               logic [31:0] data);
    store_lanes_t lanes;
    case (size)
      SizeByte: begin
        lanes.wdata = {4{data[7:0]}};
        lanes.wstrb = 4'b0001 << offset;
      end
      SizeHalf: begin
        lanes.wdata = {2{data[15:0]}};
        lanes.wstrb = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lanes.wdata = data;
        lanes.wstrb = 4'b1111;
      end
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/busio_load_align.sv
// Combinational load extract and sign/zero extension of a bus word.
module busio_load_align
  import busio_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to a full word
  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SizeByte: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SizeHalf: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default:  data_o = word_i;
    endcase
  end

endmodule

// File: rtl/busio_data.sv
// Memory-stage bus responder: one valid/ready transaction per accepted request,
// stalling the pipeline until the response has been captured.
module busio_data
  import busio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        mem_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_busy,
  output logic        ext_valid,
  input  logic        ext_ready,
  output logic [31:0] ext_address,
  output logic        ext_write,
  output logic [31:0] ext_wdata,
  output logic [3:0]  ext_wstrb,
  input  logic        ext_rvalid,
  input  logic [31:0] ext_rdata
);

  state_e       state_q, state_d;
  logic [31:0]  addr_q;
  logic [1:0]   size_q;
  logic         signed_q;
  logic         write_q;
  logic [31:0]  wdata_q;
  logic [3:0]   wstrb_q;
  logic [31:0]  raw_q;
  logic         req_valid;
  logic         capture;
  store_lanes_t lanes;

  assign req_valid = (mem_load | mem_store) & (mem_size != SizeRsvd);
  assign capture   = (state_q == StIdle) & req_valid;
  assign lanes     = store_lanes(mem_size, mem_address[1:0], mem_store_data);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: request -> handshake -> response -> hold until the stage moves on
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid)  state_d = StReq;
      StReq:   if (ext_ready)  state_d = StResp;
      StResp:  if (ext_rvalid) state_d = StDone;
      StDone:  if (!mem_stall) state_d = StIdle;
    endcase
  end

  // Outputs: busy covers the capture cycle so the stage freezes immediately
  always_comb begin
    mem_busy  = 1'b0;
    ext_valid = 1'b0;
    unique case (state_q)
      StIdle:  mem_busy = req_valid;
      StReq: begin
        mem_busy  = 1'b1;
        ext_valid = 1'b1;
      end
      StResp:  mem_busy = 1'b1;
      StDone:  mem_busy = 1'b0;
    endcase
  end

  // Request capture; later changes on the mem_* inputs never disturb the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      size_q   <= SizeByte;
      signed_q <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (capture) begin
      addr_q   <= mem_address;
      size_q   <= mem_size;
      signed_q <= mem_signed;
      write_q  <= mem_store;  // store wins when both strobes are set
      wdata_q  <= lanes.wdata;
      wstrb_q  <= mem_store ? lanes.wstrb : 4'b0000;
    end
  end

  // Raw read word; responses outside RESP are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_q <= '0;
    end else if ((state_q == StResp) && ext_rvalid && !write_q) begin
      raw_q <= ext_rdata;
    end
  end

  assign ext_address = {addr_q[31:2], 2'b00};
  assign ext_write   = write_q;
  assign ext_wdata   = wdata_q;
  assign ext_wstrb   = wstrb_q;

  busio_load_align u_load_align (
    .word_i   (raw_q),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (mem_load_data)
  );

endmodule
